// File: rtl/config_loader.sv
// Serial configuration bitstream loader.
// Hunts for a sync byte, then parses frames of {5-bit target, payload, even parity}
// and issues a one-cycle write strobe with the target address and payload word.
// Logic tiles take TILE_W-bit payloads; switch boxes take SB_W-bit payloads
// zero-extended into cfg_word. The end-of-configuration command locks the loader
// until reset.
module config_loader #(
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter int unsigned NUM_TILES = 9,
    parameter int unsigned NUM_SB    = 13,
    parameter int unsigned TILE_W    = 33,
    parameter int unsigned SB_W      = 16,
    parameter logic [4:0]  END_ADDR  = 5'd31
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic [4:0]        cfg_addr,
    output logic [TILE_W-1:0] cfg_word,
    output logic              cfg_we,
    output logic              cfg_busy,
    output logic              cfg_err,
    output logic              cfg_done
);

    localparam int unsigned LEN_W = $clog2(TILE_W + 1);

    localparam logic [2:0] HUNT    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] COMMIT  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]        state;
    logic [7:0]        sync_sr;
    logic [4:0]        addr_sr;
    logic [TILE_W-1:0] pay_sr;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_last;
    logic              par;
    logic              is_end;

    // Decode of the address as it completes on the fifth address bit
    logic [4:0]        addr_full;
    logic              addr_tile;
    logic              addr_sb;
    logic              addr_end;

    // Combinational address classification for the bit being sampled
    always_comb begin
        addr_full = {addr_sr[3:0], cfg_bit};
        addr_tile = (32'(addr_full) < NUM_TILES);
        addr_sb   = !addr_tile && (32'(addr_full) < NUM_TILES + NUM_SB);
        addr_end  = (addr_full == END_ADDR);
    end

    // Busy whenever a frame is being parsed or committed
    always_comb begin
        cfg_busy = (state == ADDR) || (state == PAYLOAD) ||
                   (state == PARITY) || (state == COMMIT);
        cfg_done = (state == DONE);
    end

    // Frame parser FSM, shift registers and registered write port
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= HUNT;
            sync_sr  <= '0;
            addr_sr  <= '0;
            pay_sr   <= '0;
            cnt      <= '0;
            len_last <= '0;
            par      <= 1'b0;
            is_end   <= 1'b0;
            cfg_addr <= '0;
            cfg_word <= '0;
            cfg_we   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_we <= 1'b0;
            case (state)
                HUNT: begin
                    if (cfg_valid) begin
                        sync_sr <= {sync_sr[6:0], cfg_bit};
                        if ({sync_sr[6:0], cfg_bit} == SYNC) begin
                            state   <= ADDR;
                            cnt     <= '0;
                            par     <= 1'b0;
                            addr_sr <= '0;
                            pay_sr  <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (cfg_valid) begin
                        addr_sr <= addr_full;
                        par     <= par ^ cfg_bit;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LEN_W'(4)) begin
                            cnt    <= '0;
                            is_end <= addr_end;
                            if (addr_tile) begin
                                len_last <= LEN_W'(TILE_W - 1);
                                state    <= PAYLOAD;
                            end else if (addr_sb) begin
                                len_last <= LEN_W'(SB_W - 1);
                                state    <= PAYLOAD;
                            end else if (addr_end) begin
                                state <= PARITY;
                            end else begin
                                cfg_err <= 1'b1;
                                state   <= HUNT;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (cfg_valid) begin
                        // Shifting from a cleared register places the first bit at len-1
                        pay_sr <= {pay_sr[TILE_W-2:0], cfg_bit};
                        par    <= par ^ cfg_bit;
                        cnt    <= cnt + 1'b1;
                        if (cnt == len_last) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (cfg_valid) begin
                        if (par ^ cfg_bit) begin
                            cfg_err <= 1'b1;
                            state   <= HUNT;
                        end else if (is_end) begin
                            state <= DONE;
                        end else begin
                            cfg_we   <= 1'b1;
                            cfg_addr <= addr_sr;
                            cfg_word <= pay_sr;
                            state    <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state <= HUNT;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: directed frame table, multi-cycle
// corner sequences, and randomized streams against a queue-based frame model.
module tb_config_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_bit = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [4:0]  cfg_addr;
    logic [32:0] cfg_word;
    logic        cfg_we;
    logic        cfg_busy;
    logic        cfg_err;
    logic        cfg_done;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    config_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_word  (cfg_word),
        .cfg_we    (cfg_we),
        .cfg_busy  (cfg_busy),
        .cfg_err   (cfg_err),
        .cfg_done  (cfg_done)
    );

    // Clock generation
    always #5 clock = ~clock;

    // Reference model: bits seen while hunting and bits of the current frame
    logic        hunt_q[$];
    logic        frame_q[$];
    logic        m_inframe = 1'b0;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [32:0] m_word = '0;
    int          m_len = 0;
    int          m_a = 0;

    function automatic int frame_addr();
        int a = 0;
        for (int i = 0; i < 5; i++) a = (a << 1) | int'(frame_q[i]);
        return a;
    endfunction

    task automatic model_edge(input logic rn, input logic v, input logic b);
        if (!rn) begin
            m_inframe = 1'b0; m_we = 1'b0; m_err = 1'b0; m_done = 1'b0;
            m_addr = '0; m_word = '0;
            hunt_q.delete(); frame_q.delete();
        end else if (m_done) begin
            // locked until reset
        end else if (m_we) begin
            m_we = 1'b0;              // commit cycle, input bit dropped
        end else if (v) begin
            if (!m_inframe) begin
                logic [7:0] w;
                hunt_q.push_back(b);
                if (hunt_q.size() > 8) void'(hunt_q.pop_front());
                w = '0;
                foreach (hunt_q[i]) w = {w[6:0], hunt_q[i]};
                if (hunt_q.size() == 8 && w == 8'hA5) begin
                    m_inframe = 1'b1;
                    frame_q.delete();
                end
            end else begin
                frame_q.push_back(b);
                if (frame_q.size() == 5) begin
                    m_a = frame_addr();
                    if (m_a < 9) m_len = 33;
                    else if (m_a < 22) m_len = 16;
                    else if (m_a == 31) m_len = 0;
                    else begin
                        m_err = 1'b1;
                        m_inframe = 1'b0;
                    end
                end else if (frame_q.size() == 5 + m_len + 1) begin
                    logic p = 1'b0;
                    logic [32:0] pw = '0;
                    foreach (frame_q[i]) p ^= frame_q[i];
                    for (int i = 5; i < 5 + m_len; i++) pw = {pw[31:0], frame_q[i]};
                    m_inframe = 1'b0;
                    if (p) m_err = 1'b1;
                    else if (m_a == 31) m_done = 1'b1;
                    else begin
                        m_we = 1'b1;
                        m_addr = 5'(m_a);
                        m_word = pw;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare outputs
    task automatic step(input logic rn, input logic v, input logic b);
        logic [42:0] got, exp;
        reset_n = rn; cfg_valid = v; cfg_bit = b;
        @(posedge clock);
        model_edge(rn, v, b);
        #1;
        if (cfg_we === 1'b1) pulses++;
        got = {cfg_we, cfg_busy, cfg_err, cfg_done, cfg_addr, cfg_word};
        exp = {m_we, m_inframe | m_we, m_err, m_done, m_addr, m_word};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL cycle_model t=%0t: got we=%b busy=%b err=%b done=%b addr=%0d word=%h, required we=%b busy=%b err=%b done=%b addr=%0d word=%h",
                     $time, cfg_we, cfg_busy, cfg_err, cfg_done, cfg_addr, cfg_word,
                     exp[42], exp[41], exp[40], exp[39], m_addr, m_word);
        end
    endtask

    task automatic send_bits(input logic [32:0] val, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap == 2) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) step(1'b1, 1'b0, 1'($urandom));
            end
            step(1'b1, 1'b1, val[i]);
            if (gap == 1) step(1'b1, 1'b0, 1'($urandom));
        end
    endtask

    task automatic send_frame(input logic [4:0] a, input logic [32:0] pay, input int len,
                              input logic flip, input int gap);
        logic p;
        p = ^a ^ flip;
        for (int i = 0; i < len; i++) p ^= pay[i];
        send_bits(33'h0, 8, gap);
        send_bits(33'hA5, 8, gap);
        send_bits(33'(a), 5, gap);
        if (len > 0) send_bits(pay, len, gap);
        send_bits(33'(p), 1, gap);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [32:0] payload;
        int          len;
        logic        flip;
        int          gap;
        int          exp_pulses;
        logic [4:0]  exp_addr;
        logic [32:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int p0;
        tbl[0] = '{5'd0,  33'h1_0000_0001, 33, 1'b0, 0, 1, 5'd0,  33'h1_0000_0001, 1'b0};
        tbl[1] = '{5'd9,  33'h0_0000_8421, 16, 1'b0, 1, 1, 5'd9,  33'h0_0000_8421, 1'b0};
        tbl[2] = '{5'd9,  33'h0_0000_8421, 16, 1'b1, 0, 0, 5'd9,  33'h0_0000_8421, 1'b1};
        tbl[3] = '{5'd8,  33'h0,           33, 1'b0, 0, 1, 5'd8,  33'h0,           1'b1};
        tbl[4] = '{5'd21, 33'h0_0000_FFFF, 16, 1'b0, 2, 1, 5'd21, 33'h0_0000_FFFF, 1'b1};
        tbl[5] = '{5'd3,  33'h1_FFFF_FFFF, 33, 1'b0, 2, 1, 5'd3,  33'h1_FFFF_FFFF, 1'b1};

        // Reset state
        do_reset();
        check("reset_outputs", {cfg_we, cfg_busy, cfg_err, cfg_done, cfg_addr, cfg_word}, 64'h0);

        // Table of frames applied back to back
        for (int i = 0; i < 6; i++) begin
            p0 = pulses;
            send_frame(tbl[i].addr, tbl[i].payload, tbl[i].len, tbl[i].flip, tbl[i].gap);
            check($sformatf("tbl%0d_pulses", i), 64'(pulses - p0), 64'(tbl[i].exp_pulses));
            check($sformatf("tbl%0d_addr", i), 64'(cfg_addr), 64'(tbl[i].exp_addr));
            check($sformatf("tbl%0d_word", i), 64'(cfg_word), 64'(tbl[i].exp_word));
            check($sformatf("tbl%0d_err", i), 64'(cfg_err), 64'(tbl[i].exp_err));
        end

        // Invalid address aborts right after the fifth address bit
        do_reset();
        send_bits(33'h0, 8, 0);
        send_bits(33'hA5, 8, 0);
        send_bits(33'd22, 5, 0);
        check("badaddr_err", 64'(cfg_err), 64'd1);
        check("badaddr_busy", 64'(cfg_busy), 64'd0);
        p0 = pulses;
        send_frame(5'd5, 33'h0_DEAD_BEEF, 33, 1'b0, 0);
        check("badaddr_next_pulses", 64'(pulses - p0), 64'd1);
        check("badaddr_next_addr", 64'(cfg_addr), 64'd5);
        check("badaddr_next_word", 64'(cfg_word), 64'h0_DEAD_BEEF);

        // End command locks the loader
        do_reset();
        send_bits(33'h0, 8, 0);
        send_bits(33'hA5, 8, 0);
        send_bits(33'd31, 5, 0);
        send_bits(33'd1, 1, 0);
        check("end_done", 64'(cfg_done), 64'd1);
        check("end_busy", 64'(cfg_busy), 64'd0);
        p0 = pulses;
        send_frame(5'd0, 33'h1_0000_0001, 33, 1'b0, 0);
        check("end_locked_pulses", 64'(pulses - p0), 64'd0);
        check("end_still_done", 64'(cfg_done), 64'd1);

        // Reset in the middle of a tile payload
        do_reset();
        send_frame(5'd2, 33'h0_1234_5678, 33, 1'b0, 0);
        send_bits(33'h0, 8, 0);
        send_bits(33'hA5, 8, 0);
        send_bits(33'd22, 5, 0);
        send_bits(33'h0, 8, 0);
        send_bits(33'hA5, 8, 0);
        send_bits(33'd0, 5, 0);
        send_bits(33'h1_0000_0003 >> 23, 10, 0);
        step(1'b0, 1'b1, 1'b1);
        check("midreset_outputs", {cfg_we, cfg_busy, cfg_err, cfg_done, cfg_addr, cfg_word}, 64'h0);
        p0 = pulses;
        send_bits(33'h3, 23, 0);
        send_bits(33'd0, 1, 0);
        step(1'b1, 1'b0, 1'b0);
        check("midreset_no_pulse", 64'(pulses - p0), 64'd0);

        // Randomized streams against the model
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 4) begin
                do_reset();
            end else if (r < 12) begin
                int k = int'($urandom_range(1, 12));
                for (int j = 0; j < k; j++) step(1'b1, 1'($urandom), 1'($urandom));
            end else begin
                int sel = int'($urandom_range(0, 99));
                logic [4:0] a;
                int len;
                if (sel < 2) a = 5'd31;
                else if (sel < 10) a = 5'(22 + $urandom_range(0, 8));
                else a = 5'($urandom_range(0, 21));
                len = (a < 9) ? 33 : (a < 22) ? 16 : 0;
                send_frame(a, {1'($urandom), 32'($urandom)}, len,
                           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)));
                if (cfg_done && $urandom_range(0, 1) == 1) do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
